// File: rtl/dmem_pkg.sv
// Shared definitions for the handshaked data memory.
//   - FSM state encoding (IDLE / BUSY / RESP)
//   - latency counter width
//   - byte-lane count helper
package dmem_pkg;

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] BUSY = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    // Wide enough for LATENCY-1 with LATENCY up to 15.
    localparam int CNT_W = 4;

    function automatic int lane_count(input int data_w);
        return data_w / 8;
    endfunction

endpackage

// File: rtl/dmem_array.sv
// Storage array for dmem_hs with per-lane byte-enable writes and a
// registered read port.
//   clk      in  clock, rising edge
//   rst      in  asynchronous active-high reset (read register only)
//   wr_en_i  in  commit a write at this edge
//   rd_en_i  in  capture memory_array[addr_i] into rdata_o at this edge
//   clr_i    in  zero rdata_o at this edge (error response)
//   addr_i   in  word address, guaranteed < DEPTH when wr_en_i/rd_en_i
//   wdata_i  in  write data
//   be_i     in  byte enables, one per 8-bit lane
//   rdata_o  out registered read data; zeroed by writes and clr_i
module dmem_array
    import dmem_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter int DEPTH  = 256
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          wr_en_i,
    input  logic                          rd_en_i,
    input  logic                          clr_i,
    input  logic [ADDR_W-1:0]             addr_i,
    input  logic [DATA_W-1:0]             wdata_i,
    input  logic [lane_count(DATA_W)-1:0] be_i,
    output logic [DATA_W-1:0]             rdata_o
);

    localparam int LANES = lane_count(DATA_W);

    logic [DATA_W-1:0] memory_array [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // NOTE: the storage array has no reset branch; resetting a RAM would
    // forbid mapping it onto memory macros and is not needed functionally.
    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            for (int b = 0; b < LANES; b++) begin
                if (be_i[b]) begin
                    memory_array[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    // NOTE: sequential state is always assigned with <= so every register
    // samples the values from before the edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (rd_en_i) begin
            rdata_q <= memory_array[addr_i];
        end else if (wr_en_i || clr_i) begin
            rdata_q <= '0;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_hs.sv
// Handshaked data memory: valid/ready request channel, valid/ready response
// channel, programmable access latency, one outstanding access at a time.
//   clk        in  clock, rising edge
//   rst        in  asynchronous active-high reset
//   req_valid  in  request present
//   req_ready  out block can accept a request (IDLE and not in reset)
//   req_we     in  1 = write, 0 = read
//   req_addr   in  word address
//   req_wdata  in  write data
//   req_be     in  byte enables (writes only)
//   rsp_valid  out response present
//   rsp_ready  in  consumer accepts response
//   rsp_rdata  out read data; 0 for writes and errors
//   rsp_err    out address was >= DEPTH
module dmem_hs
    import dmem_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int ADDR_W  = 8,
    parameter int DEPTH   = 256,
    parameter int LATENCY = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          req_valid,
    output logic                          req_ready,
    input  logic                          req_we,
    input  logic [ADDR_W-1:0]             req_addr,
    input  logic [DATA_W-1:0]             req_wdata,
    input  logic [lane_count(DATA_W)-1:0] req_be,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [DATA_W-1:0]             rsp_rdata,
    output logic                          rsp_err
);

    localparam int LANES = lane_count(DATA_W);
    // One extra bit so DEPTH == 2**ADDR_W is representable.
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              we_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [LANES-1:0]  be_q;
    logic              rsp_err_q;

    logic accept;
    logic access;
    logic in_range;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state logic
    // NOTE: every variable written here gets a default first, so no path
    // leaves it unassigned and no latch is inferred.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = BUSY;
                    cnt_d   = CNT_W'(LATENCY - 1);
                end
            end
            BUSY: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    state_d = RESP;
                end
            end
            RESP: begin
                if (rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Output logic
    always_comb begin
        accept    = (state_q == IDLE) && req_valid;
        access    = (state_q == BUSY) && (cnt_q == '0);
        // Gated by rst directly so ready drops the moment reset asserts.
        req_ready = (state_q == IDLE) && !rst;
        rsp_valid = (state_q == RESP);
    end

    // Request inputs are captured only at the accept edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            be_q    <= '0;
        end else if (accept) begin
            we_q    <= req_we;
            addr_q  <= req_addr;
            wdata_q <= req_wdata;
            be_q    <= req_be;
        end
    end

    assign in_range = {1'b0, addr_q} < DEPTH_L;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_err_q <= 1'b0;
        end else if (access) begin
            rsp_err_q <= !in_range;
        end
    end

    dmem_array #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .DEPTH  (DEPTH)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .wr_en_i (access && in_range && we_q),
        .rd_en_i (access && in_range && !we_q),
        .clr_i   (access && !in_range),
        .addr_i  (addr_q),
        .wdata_i (wdata_q),
        .be_i    (be_q),
        .rdata_o (rsp_rdata)
    );

    assign rsp_err = rsp_err_q;

endmodule

// File: tb/tb_dmem_hs.sv
module tb_dmem_hs;

    localparam int DW     = 16;
    localparam int AW     = 8;
    localparam int DEPTH  = 200;
    localparam int LAT    = 2;
    localparam int LAT4   = 4;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Main instance: DEPTH=200, LATENCY=2
    logic        rst = 1'b1;
    logic        req_valid = 1'b0, req_ready, req_we = 1'b0;
    logic [7:0]  req_addr = '0;
    logic [15:0] req_wdata = '0;
    logic [1:0]  req_be = '0;
    logic        rsp_valid, rsp_ready = 1'b0, rsp_err;
    logic [15:0] rsp_rdata;

    dmem_hs #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEPTH), .LATENCY(LAT)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .req_be(req_be),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
    );

    // Second instance: DEPTH=256, LATENCY=4 (reset-abort scenario)
    logic        rst4 = 1'b1;
    logic        req_valid4 = 1'b0, req_ready4, req_we4 = 1'b0;
    logic [7:0]  req_addr4 = '0;
    logic [15:0] req_wdata4 = '0;
    logic [1:0]  req_be4 = '0;
    logic        rsp_valid4, rsp_ready4 = 1'b0, rsp_err4;
    logic [15:0] rsp_rdata4;

    dmem_hs #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(256), .LATENCY(LAT4)) dut4 (
        .clk(clk), .rst(rst4),
        .req_valid(req_valid4), .req_ready(req_ready4), .req_we(req_we4),
        .req_addr(req_addr4), .req_wdata(req_wdata4), .req_be(req_be4),
        .rsp_valid(rsp_valid4), .rsp_ready(rsp_ready4),
        .rsp_rdata(rsp_rdata4), .rsp_err(rsp_err4)
    );

    // Reference model of the main instance's storage
    logic [15:0] model_mem [256];

    // Expected response of one access; updates the model for in-range writes.
    task automatic model_access(input logic we, input logic [7:0] addr,
                                input logic [15:0] wdata, input logic [1:0] be,
                                output logic [15:0] exp_rdata, output logic exp_err);
        if (int'(addr) >= DEPTH) begin
            exp_rdata = 16'h0000;
            exp_err   = 1'b1;
        end else if (we) begin
            for (int b = 0; b < 2; b++)
                if (be[b]) model_mem[addr][8*b +: 8] = wdata[8*b +: 8];
            exp_rdata = 16'h0000;
            exp_err   = 1'b0;
        end else begin
            exp_rdata = model_mem[addr];
            exp_err   = 1'b0;
        end
    endtask

    // Drives one access on the main instance and returns what it observed.
    // lat = edges from accept to rsp_valid, -1 on timeout.
    task automatic xact(input logic we, input logic [7:0] addr,
                        input logic [15:0] wdata, input logic [1:0] be,
                        input int stall,
                        output int lat, output logic [15:0] rdata, output logic err,
                        output bit stable, output bit back_idle);
        int k;
        lat = -1; rdata = 'x; err = 1'bx; stable = 1'b0; back_idle = 1'b0;
        req_we = we; req_addr = addr; req_wdata = wdata; req_be = be;
        req_valid = 1'b1; rsp_ready = 1'b0;
        k = 0;
        while (!req_ready && k < 20) begin @(posedge clk); #1; k++; end
        if (!req_ready) begin req_valid = 1'b0; return; end
        @(posedge clk); #1;
        // Scramble the request after accept; it must have no effect.
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = 8'($urandom);
        req_wdata = 16'($urandom); req_be = 2'($urandom);
        k = 0;
        while (!rsp_valid && k < 20) begin @(posedge clk); #1; k++; end
        if (!rsp_valid) return;
        lat = k; rdata = rsp_rdata; err = rsp_err; stable = 1'b1;
        repeat (stall) begin
            @(posedge clk); #1;
            if (!rsp_valid || rsp_rdata !== rdata || rsp_err !== err || req_ready)
                stable = 1'b0;
        end
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        back_idle = !rsp_valid && req_ready;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        total++;
        if ({req_ready, rsp_valid, rsp_err, rsp_rdata} !== 19'h0) begin
            bad++;
            $display("FAIL reset_outputs: got rdy=%b vld=%b err=%b rdata=%h want all 0",
                     req_ready, rsp_valid, rsp_err, rsp_rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        total++;
        if (req_ready !== 1'b1) begin
            bad++;
            $display("FAIL reset_release_ready: got %b want 1", req_ready);
        end
    endtask

    task automatic check_xact(input string name, input logic we, input logic [7:0] addr,
                              input logic [15:0] wdata, input logic [1:0] be,
                              input int stall);
        int lat; logic [15:0] rd, exp_rd; logic er, exp_er; bit st, bi;
        model_access(we, addr, wdata, be, exp_rd, exp_er);
        xact(we, addr, wdata, be, stall, lat, rd, er, st, bi);
        total++;
        if (lat !== LAT || rd !== exp_rd || er !== exp_er || !st || !bi) begin
            bad++;
            $display("FAIL %s: got lat=%0d rdata=%h err=%b stable=%0d idle=%0d want lat=%0d rdata=%h err=%b stable=1 idle=1",
                     name, lat, rd, er, st, bi, LAT, exp_rd, exp_er);
        end
    endtask

    task automatic test_read_basic();
        check_xact("read22", 1'b0, 8'd22, 16'h0, 2'b00, 0);
    endtask

    task automatic test_byte_enable();
        check_xact("wr22_be01", 1'b1, 8'd22, 16'hABCD, 2'b01, 0);
        check_xact("rd22_00CD", 1'b0, 8'd22, 16'h0, 2'b00, 0);
        check_xact("wr22_be10", 1'b1, 8'd22, 16'h1234, 2'b10, 0);
        check_xact("rd22_12CD", 1'b0, 8'd22, 16'h0, 2'b00, 0);
        check_xact("wr22_be00", 1'b1, 8'd22, 16'hFFFF, 2'b00, 0);
        check_xact("rd22_keep", 1'b0, 8'd22, 16'h0, 2'b00, 0);
        total++;
        if (model_mem[22] !== 16'h12CD) begin
            bad++;
            $display("FAIL model22: got %h want 12cd", model_mem[22]);
        end
    endtask

    task automatic test_stall();
        check_xact("rd7_stall5", 1'b0, 8'd7, 16'h0, 2'b00, 5);
    endtask

    task automatic test_out_of_range();
        check_xact("wr250_err", 1'b1, 8'd250, 16'hFFFF, 2'b11, 0);
        check_xact("rd199", 1'b0, 8'd199, 16'h0, 2'b00, 0);
        check_xact("rd200_err", 1'b0, 8'd200, 16'h0, 2'b00, 0);
        check_xact("wr200_err", 1'b1, 8'd200, 16'h1111, 2'b11, 2);
        check_xact("rd255_err", 1'b0, 8'd255, 16'h0, 2'b00, 0);
    endtask

    task automatic test_back_to_back();
        int acc_cyc[3];
        logic [15:0] seen[3];
        int n_acc = 0, n_rsp = 0;
        bit rdy;
        req_we = 1'b0; req_be = 2'b11; req_addr = 8'd1; req_valid = 1'b1; rsp_ready = 1'b1;
        for (int c = 0; c < 60 && n_rsp < 3; c++) begin
            rdy = req_ready;
            @(posedge clk); #1;
            if (rdy && req_valid && n_acc < 3) begin
                acc_cyc[n_acc] = c;
                n_acc++;
                if (n_acc < 3) req_addr = 8'(n_acc + 1);
                else req_valid = 1'b0;
            end
            if (rsp_valid && n_rsp < 3) begin
                seen[n_rsp] = rsp_rdata;
                n_rsp++;
            end
        end
        req_valid = 1'b0;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        total++;
        if (n_acc != 3 || n_rsp != 3) begin
            bad++;
            $display("FAIL b2b_counts: got acc=%0d rsp=%0d want 3 3", n_acc, n_rsp);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (seen[i] !== model_mem[i + 1]) begin
                    bad++;
                    $display("FAIL b2b_data%0d: got %h want %h", i, seen[i], model_mem[i + 1]);
                end
            end
            for (int i = 0; i < 2; i++) begin
                total++;
                if (acc_cyc[i + 1] - acc_cyc[i] != LAT + 2) begin
                    bad++;
                    $display("FAIL b2b_spacing%0d: got %0d want %0d",
                             i, acc_cyc[i + 1] - acc_cyc[i], LAT + 2);
                end
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 60; i++) begin
            check_xact($sformatf("rand%0d", i), 1'($urandom),
                       8'($urandom_range(0, 255)), 16'($urandom), 2'($urandom),
                       int'($urandom_range(0, 3)));
        end
    endtask

    task automatic test_reset_busy();
        int k;
        rst4 = 1'b0;
        #1;
        req_we4 = 1'b1; req_addr4 = 8'd5; req_wdata4 = 16'h5555; req_be4 = 2'b11;
        req_valid4 = 1'b1;
        total++;
        if (req_ready4 !== 1'b1) begin
            bad++;
            $display("FAIL l4_ready_before: got %b want 1", req_ready4);
        end
        @(posedge clk); #1;
        req_valid4 = 1'b0;
        repeat (2) @(posedge clk);
        #3;
        rst4 = 1'b1;
        #1;
        total++;
        if ({req_ready4, rsp_valid4, rsp_err4, rsp_rdata4} !== 19'h0) begin
            bad++;
            $display("FAIL l4_reset_outputs: got rdy=%b vld=%b err=%b rdata=%h want all 0",
                     req_ready4, rsp_valid4, rsp_err4, rsp_rdata4);
        end
        repeat (4) @(posedge clk);
        #1;
        total++;
        if (dut4.u_array.memory_array[5] !== 16'h0005) begin
            bad++;
            $display("FAIL l4_no_commit: got %h want 0005", dut4.u_array.memory_array[5]);
        end
        rst4 = 1'b0;
        #1;
        total++;
        if (req_ready4 !== 1'b1 || rsp_valid4 !== 1'b0) begin
            bad++;
            $display("FAIL l4_after_release: got rdy=%b vld=%b want 1 0", req_ready4, rsp_valid4);
        end
        req_we4 = 1'b0; req_addr4 = 8'd5; req_valid4 = 1'b1; rsp_ready4 = 1'b1;
        @(posedge clk); #1;
        req_valid4 = 1'b0;
        k = 0;
        while (!rsp_valid4 && k < 20) begin @(posedge clk); #1; k++; end
        total++;
        if (k != LAT4 || rsp_rdata4 !== 16'h0005 || rsp_err4 !== 1'b0) begin
            bad++;
            $display("FAIL l4_read5: got lat=%0d rdata=%h err=%b want lat=%0d rdata=0005 err=0",
                     k, rsp_rdata4, rsp_err4, LAT4);
        end
        @(posedge clk); #1;
        rsp_ready4 = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            model_mem[i] = 16'(i);
            if (i < DEPTH) dut.u_array.memory_array[i] = 16'(i);
            dut4.u_array.memory_array[i] = 16'(i);
        end
        test_reset();
        test_read_basic();
        test_byte_enable();
        test_stall();
        test_out_of_range();
        test_back_to_back();
        test_random();
        test_reset_busy();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/dmem_hs.md
Name: dmem_hs

Overview:
- Parametrised, handshaked successor to the single-cycle data memory used by the 16-bit datapath.
- Adds configurable data/address width, depth, byte-enable writes, programmable access latency and a valid/ready request/response protocol. This lets the multicycle/pipelined datapath stall on memory.
- Sits between the datapath MEM stage and the storage array. Exactly one outstanding access at a time.

Parameters:
- DATA_W, 16, data word width in bits; must be a multiple of 8.
- ADDR_W, 8, word-address width.
- DEPTH, 256, number of implemented words; 1..2**ADDR_W.
- LATENCY, 2, clock edges from request accept to response valid; 1..15.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = write, 0 = read.
- req_addr  in  ADDR_W  word address.
- req_wdata  in  DATA_W  write data.
- req_be  in  DATA_W/8  byte enables for writes; ignored on reads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts response.
- rsp_rdata  out  DATA_W  read data; 0 for writes and errors.
- rsp_err  out  1  address >= DEPTH.

Behaviour:
- One clock (clk); reset is asynchronous and active-high (rst). Asserting rst immediately forces state IDLE, rsp_valid=0, rsp_rdata=0, rsp_err=0, cnt=0.
- req_ready = (state==IDLE) && !rst; it is 0 while rst is high.
- Storage array (memory_array) is not reset; the bench preloads it hierarchically.
- States:
  - IDLE: if req_valid, accept at that edge. Latch we/addr/wdata/be, cnt<=LATENCY-1, go BUSY.
  - BUSY: if cnt!=0, cnt<=cnt-1. If cnt==0, perform the access at this edge and go RESP.
  - RESP: rsp_valid=1, and rsp_rdata/rsp_err are held stable until rsp_valid&&rsp_ready. Then go IDLE.
- Latency: request accepted at edge N gives rsp_valid high after edge N+LATENCY. Minimum turnaround is LATENCY+2 cycles per access, because IDLE always costs one cycle.
- Read, addr<DEPTH: rsp_rdata<=memory_array[addr], rsp_err<=0.
- Write, addr<DEPTH: for each lane b with be[b]=1, memory_array[addr][8b+7:8b]<=wdata lane b. Lanes with be[b]=0 are unchanged. rsp_rdata<=0, rsp_err<=0.
- be=0 on a write: no change to memory; normal response returned.
- addr>=DEPTH (read or write): no memory change, rsp_rdata<=0, rsp_err<=1.
- Request inputs are sampled only at the accept edge. Changes afterwards have no effect.
- req_valid in BUSY/RESP is ignored (not accepted).
- rsp_ready high outside RESP is ignored.
- Reset during BUSY: access aborted, a pending write is never committed, and no response is issued.
- Reset during RESP: response dropped; memory already holds the committed write.

Decomposition:
- Shared package dmem_pkg:
  - state encoding localparams IDLE=2'd0, BUSY=2'd1, RESP=2'd2;
  - function for lane count DATA_W/8;
  - cnt width constant of 4 bits.
- One sub-module dmem_array (parameters DATA_W, ADDR_W, DEPTH):
  - synchronous per-lane byte-enable write and registered read;
  - exposes memory_array for hierarchical preload.
- Top-level dmem_hs holds the FSM, counter, request latch and range check.

Test Plan:
- Preload memory_array[i]=i. Read addr 22 with LATENCY=2, rsp_ready=1 -> rsp_valid rises 2 edges after accept, rsp_rdata=16'h0016, rsp_err=0, req_ready back to 1 one cycle later.
- Write addr 22, wdata 16'hABCD, be=2'b01, then read 22 -> rsp_rdata=16'h00CD. Write be=2'b10 wdata 16'h1234, read -> 16'h12CD.
- Hold rsp_ready=0 for 5 cycles after a read of addr 7 -> rsp_valid stays 1, rsp_rdata=16'h0007 stable, req_ready=0 throughout. Raise rsp_ready -> IDLE next edge.
- DEPTH=200: write addr 250 wdata 16'hFFFF be=2'b11 -> rsp_err=1, rsp_rdata=0. memory_array unchanged, confirmed by read of addr 199 returning 16'h00C7.
- LATENCY=4: issue write addr 5 wdata 16'h5555, assert rst asynchronously 2 cycles after accept -> outputs 0 immediately, memory_array[5] still 16'h0005. After release, req_ready=1 and a read of 5 returns 16'h0005.
- Back-to-back: req_valid held high with 3 reads (addr 1,2,3) -> each accepted only in IDLE, responses 1,2,3 in order, each LATENCY+2 cycles apart.
